// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the pipelined immediate generator.
// Optional feature macro used by the decoder: CSR_ZIMM_EN.
package imm_gen_pkg;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6,
      FMT_NONE = 3'd7
   } fmt_e;

   // Major opcodes, inst[6:2] (inst[1:0] must be 2'b11)
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_IMM    = 5'b00100;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_IMM32  = 5'b00110;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_REG    = 5'b01100;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_REG32  = 5'b01110;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_SYSTEM = 5'b11100;

   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational instruction classifier and immediate extender (module imm_decode).
// CSR_ZIMM_EN: SYSTEM with inst[14]=1 reports format Z and a zero-extended rs1 field.
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output logic [XLEN-1:0] imm,
   output fmt_e            fmt,
   output logic            illegal
);

   logic [31:0] imm32;

   // Every immediate is built as a sign-correct 32-bit value first, so the
   // final widening to XLEN is a plain sign extension for all formats.
   always_comb begin
      imm32 = '0;
      fmt   = FMT_NONE;
      if (inst[1:0] == 2'b11) begin
         case (inst[6:2])
            OP_REG: fmt = FMT_R;
            OP_LOAD, OP_IMM, OP_JALR: begin
               fmt   = FMT_I;
               imm32 = sext12(inst[31:20]);
            end
            OP_STORE: begin
               fmt   = FMT_S;
               imm32 = sext12({inst[31:25], inst[11:7]});
            end
            OP_BRANCH: begin
               fmt   = FMT_B;
               imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
               fmt   = FMT_U;
               imm32 = {inst[31:12], 12'b0};
            end
            OP_JAL: begin
               fmt   = FMT_J;
               imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OP_SYSTEM: begin
`ifdef CSR_ZIMM_EN
               if (inst[14]) begin
                  fmt   = FMT_Z;
                  imm32 = {27'b0, inst[19:15]};
               end else begin
                  fmt   = FMT_I;
                  imm32 = sext12(inst[31:20]);
               end
`else
               fmt   = FMT_I;
               imm32 = sext12(inst[31:20]);
`endif
            end
            OP_REG32: begin
               if (XLEN == 64) fmt = FMT_R;
            end
            OP_IMM32: begin
               if (XLEN == 64) begin
                  fmt   = FMT_I;
                  imm32 = sext12(inst[31:20]);
               end
            end
            default: begin
               fmt   = FMT_NONE;
               imm32 = '0;
            end
         endcase
      end
   end

   assign illegal = (fmt == FMT_NONE);
   assign imm     = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode on accept, in-order output FIFO, saturating illegal counter.
// Optional feature macro: CSR_ZIMM_EN (handled inside imm_decode).
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_inst,
   input  logic [XLEN-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_imm,
   output logic [2:0]        out_fmt,
   output logic              out_illegal,
   output logic [XLEN-1:0]   out_pc,
   output logic [CNT_W-1:0]  illegal_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [XLEN-1:0]  imm_mem [DEPTH];
   logic [XLEN-1:0]  pc_mem  [DEPTH];
   logic [2:0]       fmt_mem [DEPTH];
   logic             ill_mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   logic [XLEN-1:0]  dec_imm;
   fmt_e             dec_fmt;
   logic             dec_illegal;

   logic             full;
   logic             push;
   logic             pop;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .inst    (in_inst),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_illegal)
   );

   // Ready depends only on stored occupancy (plus reset), never on out_ready,
   // so a full FIFO refuses input even in a cycle where it is also popped.
   assign full      = (count == FULL_CNT);
   assign in_ready  = rst_n && !full;
   assign out_valid = rst_n && (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         imm_mem[wr_ptr] <= dec_imm;
         pc_mem[wr_ptr]  <= in_pc;
         fmt_mem[wr_ptr] <= dec_fmt;
         ill_mem[wr_ptr] <= dec_illegal;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         illegal_cnt <= '0;
      end else if (push && dec_illegal && (illegal_cnt != '1)) begin
         illegal_cnt <= illegal_cnt + 1'b1;
      end
   end

   // Head slot is never written while valid, so the gated outputs hold during a stall.
   assign out_imm     = out_valid ? imm_mem[rd_ptr] : '0;
   assign out_pc      = out_valid ? pc_mem[rd_ptr]  : '0;
   assign out_fmt     = out_valid ? fmt_mem[rd_ptr] : FMT_NONE;
   assign out_illegal = out_valid ? ill_mem[rd_ptr] : 1'b0;

endmodule
